// File: rtl/velocity_settle_pkg.sv
// Shared physics types: settle FSM states and the default velocity component type.
package velocity_settle_pkg;

  localparam int unsigned VEL_WIDTH = 32;

  typedef logic signed [VEL_WIDTH-1:0] vel_t;

  typedef enum logic [1:0] {
    MOVING   = 2'd0,
    SETTLING = 2'd1,
    RESTING  = 2'd2
  } settle_state_t;

endpackage

// File: rtl/velocity_settle_close_to_zero.sv
// Combinational check that one signed velocity component lies within +/-2^TOL inclusive.
module close_to_zero #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TOL   = 10
) (
  input  logic signed [WIDTH-1:0] v,
  output logic                    close_c
);

  localparam logic signed [WIDTH-1:0] LIM_POS = WIDTH'(1) << TOL;
  localparam logic signed [WIDTH-1:0] LIM_NEG = -LIM_POS;

  assign close_c = (v <= LIM_POS) && (v >= LIM_NEG);

endmodule

// File: rtl/velocity_settle.sv
// Per-ball settle stage: counts consecutive near-zero frames and snaps velocity to zero at rest.
// Optional friction (v - v>>>FRIC_SHIFT) is compiled in with VELOCITY_SETTLE_FRICTION_EN.
module velocity_settle
  import velocity_settle_pkg::*;
#(
  parameter int unsigned WIDTH         = VEL_WIDTH,
  parameter int unsigned TOL           = 10,
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned FRIC_SHIFT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_vx,
  input  logic signed [WIDTH-1:0] in_vy,
  input  logic                    kick,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_vx,
  output logic signed [WIDTH-1:0] out_vy,
  output logic                    at_rest
);

  localparam int unsigned   CW      = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_FRAMES);

`ifdef VELOCITY_SETTLE_FRICTION_EN
  localparam bit FRIC_EN = 1'b1;
`else
  localparam bit FRIC_EN = 1'b0;
`endif

  settle_state_t           state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic signed [WIDTH-1:0] vx_p, vy_p;
  logic signed [WIDTH-1:0] out_vx_d, out_vy_d;
  logic                    out_valid_d, at_rest_d;
  logic                    close_x, close_y, accept;

  // Friction never overflows: |v'| <= |v| apart from the most-negative input, which stays in range.
  assign vx_p = FRIC_EN ? (in_vx - (in_vx >>> FRIC_SHIFT)) : in_vx;
  assign vy_p = FRIC_EN ? (in_vy - (in_vy >>> FRIC_SHIFT)) : in_vy;

  close_to_zero #(.WIDTH(WIDTH), .TOL(TOL)) u_close_x (.v(vx_p), .close_c(close_x));
  close_to_zero #(.WIDTH(WIDTH), .TOL(TOL)) u_close_y (.v(vy_p), .close_c(close_y));

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = CW'(cnt_q + CW'(1));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    out_vx_d    = out_vx;
    out_vy_d    = out_vy;
    at_rest_d   = at_rest;

    if (kick) begin
      state_d = MOVING;
      cnt_d   = '0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_vx_d    = vx_p;
      out_vy_d    = vy_p;
      at_rest_d   = 1'b0;
      if (!kick) begin
        if (!(close_x && close_y)) begin
          state_d = MOVING;
          cnt_d   = '0;
        end else if (state_q == RESTING) begin
          out_vx_d  = '0;
          out_vy_d  = '0;
          at_rest_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d   = RESTING;
            out_vx_d  = '0;
            out_vy_d  = '0;
            at_rest_d = 1'b1;
          end else begin
            state_d = SETTLING;
          end
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MOVING;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_vx    <= '0;
      out_vy    <= '0;
      at_rest   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      out_vx    <= out_vx_d;
      out_vy    <= out_vy_d;
      at_rest   <= at_rest_d;
    end
  end

endmodule

// File: doc/velocity_settle.md
# velocity_settle

Per-ball settle stage in the physics pipeline, downstream of the per-component near-zero tolerance check. It consumes one velocity sample (vx, vy) per frame over a valid/ready handshake. It counts consecutive frames in which both components lie within ±2^TOL. After STABLE_FRAMES such frames it snaps the velocity to exactly zero and holds the ball at rest, so the collision and render stages see a truly stopped ball instead of fixed-point creep.

## Interface
- WIDTH, 32: signed fixed-point velocity component width.
- TOL, 10: tolerance exponent; a component is close when -2^TOL <= v <= 2^TOL (inclusive).
- STABLE_FRAMES, 4: consecutive close frames required to enter rest; must be >= 1.
- FRIC_SHIFT, 4: friction shift amount; used only with friction compiled in (see Configuration).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_vx, in_vy  in  WIDTH  signed input velocity.
- kick  in  1  single-cycle pulse; ball struck, forces exit from rest.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_vx, out_vy  out  WIDTH  signed output velocity.
- at_rest  out  1  qualifies the current output; 1 = ball settled, velocity forced to 0.

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Per accepted sample: compute v' per component (friction or pass-through). close = both v'x and v'y within tolerance. Tolerance is computed from v', never from raw input.
- Counter cnt has width $clog2(STABLE_FRAMES+1).
- FSM states:
  - MOVING: cnt = 0.
  - SETTLING: 0 < cnt < STABLE_FRAMES.
  - RESTING: cnt = STABLE_FRAMES.
- Transitions on an accepted sample without kick:
  - close in MOVING/SETTLING: cnt+1. If the result equals STABLE_FRAMES, go to RESTING; this sample is emitted as (0,0) with at_rest=1. Otherwise emit v' with at_rest=0.
  - not close in any state: cnt=0, go to MOVING, emit v' with at_rest=0.
  - close in RESTING: stay in RESTING, emit (0,0) with at_rest=1.
- kick in any state: cnt=0, go to MOVING. If a sample is accepted in the same cycle, that sample is emitted as v' with at_rest=0 and is not counted, even if it is close.
- kick with no accepted sample only changes state. The output register is untouched.
- Reset mid-operation discards any held output sample and all counter state.

## Timing
- Latency: 1 cycle, from accept to out_valid. Single output register, no skid buffer.
- in_ready = !out_valid || out_ready (combinational). Full throughput when out_ready=1.
- Output signals are stable while out_valid && !out_ready.
- Values after rst: out_valid=0, out_vx=0, out_vy=0, at_rest=0, state MOVING, cnt=0. in_ready=1 in the cycle after reset.

## Configuration
- VELOCITY_SETTLE_FRICTION_EN:
  - Defined: v' = v - (v >>> FRIC_SHIFT), using arithmetic shift. No overflow is possible, because |v'| <= |v| except for the most-negative input, which stays in range.
  - Undefined: v' = v. FRIC_SHIFT is unused.

## Structure
- Shared physics package holds the FSM state enum (MOVING, SETTLING, RESTING) and the velocity component typedef (signed [WIDTH-1:0]).
- One sub-module: close_to_zero, instantiated twice (vx, vy) with WIDTH/TOL passed through. Its combinational close output feeds the FSM.

## Test plan
WIDTH=32, TOL=10, STABLE_FRAMES=4, FRIC_SHIFT=4, out_ready=1, macro undefined unless stated.
- Reset: assert rst for 2 cycles -> out_valid=0, out_vx=out_vy=0, at_rest=0, in_ready=1.
- Settle: four samples (500,-300) -> outputs (500,-300) three times with at_rest=0, then (0,0) with at_rest=1. A fifth sample (500,-300) -> (0,0), at_rest=1.
- Break: three samples (1024,-1024), then (1025,0), then (0,0) -> no at_rest. The counter restarts and rest is reached only on the fourth close sample after (1025,0).
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0 and outputs unchanged for 5 cycles. Release -> the held sample is emitted, then the next sample is accepted.
- Kick: in RESTING, pulse kick while accepting (100,100) -> output (100,100), at_rest=0. Four further close samples are needed to re-enter rest.
- Friction (macro defined): (1600,0) -> (1500,0); (-1,0) -> (0,0); (-2^31,0) -> (-2013265920,0).
